// File: rtl/ifu_bpu_jalr_sched_pkg.sv
// ---------------------------------------------------------------------------
// ifu_bpu_jalr_sched_pkg
// Shared configuration for the JALR operand scheduler of the lite branch
// predictor.
// Contents:
//   CFG_XLEN, CFG_RFIDX_WIDTH, CFG_OITF_DEPTH : default widths and depth.
//   jalr_state_e                              : scheduler FSM state encoding.
// ---------------------------------------------------------------------------
package ifu_bpu_jalr_sched_pkg;

    localparam int CFG_XLEN        = 32;
    localparam int CFG_RFIDX_WIDTH = 5;
    localparam int CFG_OITF_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } jalr_state_e;

endpackage

// File: rtl/ifu_bpu_jalr_sched_if.sv
// ---------------------------------------------------------------------------
// ifu_bpu_jalr_sched_if
// Bundles every non-clock signal of the JALR scheduler.
//   slave  : the scheduler (consumes decode/IR/dispatch/regfile, drives BPU side)
//   master : the surrounding pipeline / testbench
// Signals:
//   dec_*            decode stage JALR request and redirect flush
//   ir_*             IR-stage pending register write
//   disp_*, wb_ret   OITF allocate / retire
//   oitf_full/empty  scoreboard status
//   exu_rf_rd_*      EXU request/grant for regfile read port 1
//   bpu_rf_rd_*      port 1 routed to the predictor and its index
//   rf_rdata         combinational port 1 read data
//   bpu_rs1(_vld)    registered rs1 value for the predictor
//   bpu_wait         IFU stall
// ---------------------------------------------------------------------------
interface ifu_bpu_jalr_sched_if #(
    parameter int XLEN    = ifu_bpu_jalr_sched_pkg::CFG_XLEN,
    parameter int RFIDX_W = ifu_bpu_jalr_sched_pkg::CFG_RFIDX_WIDTH
);
    logic               dec_i_valid;
    logic               dec_jalr;
    logic [RFIDX_W-1:0] dec_jalr_rs1idx;
    logic               dec_flush;
    logic               ir_valid;
    logic               ir_rd_wen;
    logic [RFIDX_W-1:0] ir_rdidx;
    logic               disp_alc;
    logic [RFIDX_W-1:0] disp_rdidx;
    logic               wb_ret;
    logic               oitf_full;
    logic               oitf_empty;
    logic               exu_rf_rd_req;
    logic               exu_rf_rd_gnt;
    logic               bpu_rf_rd_sel;
    logic [RFIDX_W-1:0] bpu_rf_rd_idx;
    logic [XLEN-1:0]    rf_rdata;
    logic [XLEN-1:0]    bpu_rs1;
    logic               bpu_rs1_vld;
    logic               bpu_wait;

    modport slave (
        input  dec_i_valid, dec_jalr, dec_jalr_rs1idx, dec_flush,
        input  ir_valid, ir_rd_wen, ir_rdidx,
        input  disp_alc, disp_rdidx, wb_ret,
        input  exu_rf_rd_req, rf_rdata,
        output oitf_full, oitf_empty, exu_rf_rd_gnt,
        output bpu_rf_rd_sel, bpu_rf_rd_idx, bpu_rs1, bpu_rs1_vld, bpu_wait
    );

    modport master (
        output dec_i_valid, dec_jalr, dec_jalr_rs1idx, dec_flush,
        output ir_valid, ir_rd_wen, ir_rdidx,
        output disp_alc, disp_rdidx, wb_ret,
        output exu_rf_rd_req, rf_rdata,
        input  oitf_full, oitf_empty, exu_rf_rd_gnt,
        input  bpu_rf_rd_sel, bpu_rf_rd_idx, bpu_rs1, bpu_rs1_vld, bpu_wait
    );
endinterface

// File: rtl/ifu_bpu_oitf.sv
// ---------------------------------------------------------------------------
// ifu_bpu_oitf
// In-order outstanding-instruction-track FIFO. Allocate writes rd at the tail,
// retire pops the head. Each pointer carries a wrap bit so full and empty are
// distinguishable when the indices are equal.
// Ports:
//   clk, rst        clock, async active-low reset
//   i_alc/i_alc_rdidx  allocate request and its rd (dropped when full)
//   i_ret           retire oldest entry (dropped when empty)
//   i_rs1idx        register to look up
//   o_full/o_empty  ring status (from registered pointers)
//   o_rs1_hit       per-entry match of i_rs1idx against valid, non-x0 rd
// ---------------------------------------------------------------------------
module ifu_bpu_oitf #(
    parameter int DEPTH   = 2,
    parameter int RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_alc,
    input  logic [RFIDX_W-1:0] i_alc_rdidx,
    input  logic               i_ret,
    input  logic [RFIDX_W-1:0] i_rs1idx,
    output logic               o_full,
    output logic               o_empty,
    output logic [DEPTH-1:0]   o_rs1_hit
);
    localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // {wrap, index}
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [DEPTH-1:0]   r_vld;
    logic [RFIDX_W-1:0] r_rdidx [DEPTH];

    logic w_alc_ok;
    logic w_ret_ok;

    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == LAST) begin
            return {~p[AW], {AW{1'b0}}};
        end else begin
            return {p[AW], p[AW-1:0] + AW'(1)};
        end
    endfunction

    assign o_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    // A full ring rejects allocation even when a retire frees a slot this cycle.
    assign w_alc_ok = i_alc && !o_full;
    assign w_ret_ok = i_ret && !o_empty;

    // Ring state: allocate at tail, retire at head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_vld    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rdidx[i] <= '0;
            end
        end else begin
            if (w_ret_ok) begin
                r_vld[r_rd_ptr[AW-1:0]] <= 1'b0;
                r_rd_ptr                <= ptr_inc(r_rd_ptr);
            end
            if (w_alc_ok) begin
                r_vld[r_wr_ptr[AW-1:0]]   <= 1'b1;
                r_rdidx[r_wr_ptr[AW-1:0]] <= i_alc_rdidx;
                r_wr_ptr                  <= ptr_inc(r_wr_ptr);
            end
        end
    end

    // rs1 lookup on registered entries; an x0 destination never creates a hazard.
    always_comb begin
        o_rs1_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_rs1_hit[i] = r_vld[i] && (r_rdidx[i] == i_rs1idx) && (r_rdidx[i] != '0);
        end
    end

    ifu_bpu_oitf_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .i_alc   (i_alc),
        .i_ret   (i_ret),
        .i_full  (o_full),
        .i_empty (o_empty)
    );
endmodule

// File: rtl/ifu_bpu_oitf_chk.sv
// ---------------------------------------------------------------------------
// ifu_bpu_oitf_chk
// Protocol checks for the OITF ring: flags an allocate while full and a
// retire while empty (both are dropped by the ring). Checks are compiled in
// when IFU_BPU_OITF_CHK is defined.
// Ports: clk, rst (async active-low), i_alc, i_ret, i_full, i_empty.
// ---------------------------------------------------------------------------
module ifu_bpu_oitf_chk (
    input  logic clk,
    input  logic rst,
    input  logic i_alc,
    input  logic i_ret,
    input  logic i_full,
    input  logic i_empty
);
`ifdef IFU_BPU_OITF_CHK
    a_alc_when_full: assert property (@(posedge clk) disable iff (!rst) !(i_alc && i_full));
    a_ret_when_empty: assert property (@(posedge clk) disable iff (!rst) !(i_ret && i_empty));
`else
    logic w_unused_chk;
    assign w_unused_chk = &{clk, rst, i_alc, i_ret, i_full, i_empty};
`endif
endmodule

// File: rtl/ifu_bpu_jalr_sched.sv
// ---------------------------------------------------------------------------
// ifu_bpu_jalr_sched
// Schedules the rs1 read of a decoded JALR for the lite branch predictor.
// rs1=x0 needs nothing, rs1=x1 comes from the dedicated x1 path (stall only
// on a hazard), any other rs1 borrows regfile read port 1 when the EXU is not
// using it and no older write to rs1 is outstanding.
// Ports: clk, rst (async active-low), bus (ifu_bpu_jalr_sched_if.slave).
// Configuration macro: IFU_BPU_X1_DEP_EN -- when defined an x1 JALR stalls on
// an rs1 hazard; when undefined x1 never stalls.
// ---------------------------------------------------------------------------
module ifu_bpu_jalr_sched
    import ifu_bpu_jalr_sched_pkg::*;
#(
    parameter int OITF_DEPTH = CFG_OITF_DEPTH,
    parameter int XLEN       = CFG_XLEN,
    parameter int RFIDX_W    = CFG_RFIDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    ifu_bpu_jalr_sched_if.slave   bus
);
    jalr_state_e         r_state;
    logic [XLEN-1:0]     r_bpu_rs1;
    logic                r_bpu_rs1_vld;

    jalr_state_e         w_nxt_state;
    logic                w_jreq;
    logic [RFIDX_W-1:0]  w_rs1;
    logic                w_is_x1;
    logic                w_is_xn;
    logic [OITF_DEPTH-1:0] w_oitf_hit;
    logic                w_ir_dep;
    logic                w_dep;
    logic                w_x1_wait;
    logic                w_fsm_wait;
    logic                w_sel;

    assign w_jreq   = bus.dec_i_valid && bus.dec_jalr;
    assign w_rs1    = bus.dec_jalr_rs1idx;
    assign w_is_x1  = (w_rs1 == RFIDX_W'(1));
    assign w_is_xn  = (w_rs1 != '0) && !w_is_x1;
    assign w_ir_dep = bus.ir_valid && bus.ir_rd_wen && (bus.ir_rdidx == w_rs1);
    assign w_dep    = (|w_oitf_hit) || w_ir_dep;

`ifdef IFU_BPU_X1_DEP_EN
    assign w_x1_wait = w_jreq && w_is_x1 && w_dep;
`else
    assign w_x1_wait = 1'b0;
`endif

    ifu_bpu_oitf #(
        .DEPTH   (OITF_DEPTH),
        .RFIDX_W (RFIDX_W)
    ) u_oitf (
        .clk         (clk),
        .rst         (rst),
        .i_alc       (bus.disp_alc),
        .i_alc_rdidx (bus.disp_rdidx),
        .i_ret       (bus.wb_ret),
        .i_rs1idx    (w_rs1),
        .o_full      (bus.oitf_full),
        .o_empty     (bus.oitf_empty),
        .o_rs1_hit   (w_oitf_hit)
    );

    // Next state, port-1 steal and stall for the xn path; flush overrides all.
    always_comb begin
        w_nxt_state = r_state;
        w_sel       = 1'b0;
        w_fsm_wait  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_jreq && w_is_xn) begin
                    w_fsm_wait = 1'b1;
                    if (w_dep || bus.exu_rf_rd_req) begin
                        w_nxt_state = ST_WAIT;
                    end else begin
                        w_sel       = 1'b1;
                        w_nxt_state = ST_HOLD;
                    end
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_fsm_wait = 1'b1;
                if (!w_dep && !bus.exu_rf_rd_req) begin
                    w_sel       = 1'b1;
                    w_nxt_state = ST_HOLD;
                end else begin
                    w_nxt_state = ST_WAIT;
                end
            end
            ST_HOLD: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
        if (bus.dec_flush) begin
            w_nxt_state = ST_IDLE;
            w_sel       = 1'b0;
            w_fsm_wait  = 1'b0;
        end else begin
            w_nxt_state = w_nxt_state;
        end
    end

    // FSM state plus the rs1 capture register; capture happens exactly when port 1 is stolen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_bpu_rs1     <= '0;
            r_bpu_rs1_vld <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_bpu_rs1_vld <= w_sel;
            if (w_sel) begin
                r_bpu_rs1 <= bus.rf_rdata;
            end else begin
                r_bpu_rs1 <= r_bpu_rs1;
            end
        end
    end

    // Combinational controls are gated by rst so an asserted reset quiets them at once.
    assign bus.exu_rf_rd_gnt = bus.exu_rf_rd_req;
    assign bus.bpu_rf_rd_sel = rst && w_sel;
    assign bus.bpu_rf_rd_idx = (rst && w_sel) ? w_rs1 : '0;
    assign bus.bpu_wait      = rst && !bus.dec_flush && (w_fsm_wait || w_x1_wait);
    assign bus.bpu_rs1       = r_bpu_rs1;
    assign bus.bpu_rs1_vld   = r_bpu_rs1_vld;
endmodule

// File: doc/ifu_bpu_jalr_sched.md
Name: ifu_bpu_jalr_sched

Overview:
- Schedules JALR target-operand reads for the lite branch predictor.
- Tracks outstanding long-latency register writes in a small in-order OITF scoreboard.
- Detects rs1 hazards for JALR instructions.
- Arbitrates register-file read port 1 between the EXU operand read and the BPU's rs1 read.
- Drives bpu_wait and delivers a registered rs1 value to the predictor. Sits between IFU decode, the EXU dispatch/writeback interface and the regfile.

Parameters:
- OITF_DEPTH, 2, number of outstanding long-latency writes tracked (power of 2, >=1).
- XLEN, `XLEN, data width.
- RFIDX_W, `RFIDX_WIDTH, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- dec_i_valid  in  1  decode stage holds a valid instruction.
- dec_jalr  in  1  decoded instruction is JALR.
- dec_jalr_rs1idx  in  RFIDX_W  JALR rs1 index.
- dec_flush  in  1  IFU redirect; aborts the pending schedule.
- ir_valid  in  1  IR stage holds an instruction not yet dispatched.
- ir_rd_wen  in  1  IR instruction writes rd.
- ir_rdidx  in  RFIDX_W  IR instruction rd.
- disp_alc  in  1  dispatch allocates an OITF entry (long-latency op).
- disp_rdidx  in  RFIDX_W  rd of the allocating op.
- wb_ret  in  1  oldest OITF entry retires.
- oitf_full  out  1  scoreboard full; dispatch must hold long ops.
- oitf_empty  out  1  scoreboard empty.
- exu_rf_rd_req  in  1  EXU requests read port 1 this cycle.
- exu_rf_rd_gnt  out  1  EXU granted port 1.
- bpu_rf_rd_sel  out  1  port 1 routed to the BPU this cycle.
- bpu_rf_rd_idx  out  RFIDX_W  index driven on port 1 when bpu_rf_rd_sel=1.
- rf_rdata  in  XLEN  combinational port 1 read data.
- bpu_rs1  out  XLEN  registered rs1 for the predictor.
- bpu_rs1_vld  out  1  bpu_rs1 valid this cycle.
- bpu_wait  out  1  stall the IFU.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Port names are clk and rst, with rst active-low.
- Reset values:
  - FSM state = IDLE.
  - OITF pointers 0, all entry valid bits 0.
  - oitf_empty=1, oitf_full=0.
  - bpu_rs1=0, bpu_rs1_vld=0, bpu_wait=0, bpu_rf_rd_sel=0.
- Operand classes: jreq = dec_i_valid & dec_jalr. rs1 is classed as x0, x1 or xn.
- x0: no wait, no read.
- Hazard (dep): rs1 matches a valid OITF entry rd, or (ir_valid & ir_rd_wen & ir_rdidx==rs1). Applies to x1 and xn only.
- x1: bpu_wait = jreq & x1 & dep, combinationally. x1 is read through the dedicated x1 path, so the FSM is not involved.
- FSM for xn (states IDLE, WAIT, HOLD):
  - IDLE, jreq&xn:
    - If dep or exu_rf_rd_req: go to WAIT, bpu_wait=1.
    - Otherwise: bpu_rf_rd_sel=1 and bpu_rf_rd_idx=rs1 this cycle. Capture rf_rdata into bpu_rs1 at the edge, go to HOLD. bpu_wait=1 in this cycle.
  - WAIT: bpu_wait=1. When dep clears and exu_rf_rd_req=0: grant the BPU, capture, go to HOLD.
  - HOLD: bpu_rs1_vld=1, bpu_wait=0 for exactly 1 cycle, then IDLE. New requests are not accepted in HOLD.
- Latency: no-hazard xn JALR stalls exactly 1 cycle; bpu_rs1_vld rises in the next cycle.
- Arbitration: EXU has priority. exu_rf_rd_gnt = exu_rf_rd_req always. bpu_rf_rd_sel is only asserted when exu_rf_rd_req=0, so the two are never both high.
- dec_flush: from any state, go to IDLE next cycle. bpu_wait and bpu_rf_rd_sel are forced 0 in the flush cycle. No capture occurs. OITF is unaffected.
- OITF ring:
  - Alloc writes at the tail; retire pops at the head.
  - Pointers wrap modulo OITF_DEPTH, with a wrap bit distinguishing full from empty.
  - Alloc when full: ignored, and an assertion fires. Retire when empty: ignored, and an assertion fires.
  - Simultaneous alloc+retire when not empty and not full: both take effect, and the count is unchanged.
  - Alloc in the same cycle as full is rejected even if wb_ret=1.
  - The hazard check uses the registered entries, so a same-cycle alloc does not create dep until the next cycle.
- disp_rdidx==0: entry is allocated but never matches.

Optional Feature:
- Macro IFU_BPU_X1_DEP_EN.
- Defined: x1 hazard stall as above.
- Undefined: the x1 dep term is tied 0, so x1 JALR never stalls. Software and the EXU guarantee the ordering. The xn path is unchanged.

Decomposition:
- Shared defines: PC_SIZE, XLEN, RFIDX_WIDTH, FSM state encodings (IDLE/WAIT/HOLD, 2 bits), OITF_DEPTH default.
- Sub-module ifu_bpu_oitf:
  - Contains the ring, pointers, full/empty logic and the rs1 match vector.
  - Outputs oitf_full, oitf_empty, and a per-index hit for rs1.
- The top level holds the FSM, arbitration and bpu_rs1 register.

Test Plan:
- jalr rs1=x5, no hazards, exu_rf_rd_req=0, rf_rdata=0x80001000:
  - bpu_wait=1 for 1 cycle with bpu_rf_rd_sel=1 and idx=5.
  - Next cycle bpu_rs1=0x80001000, bpu_rs1_vld=1, bpu_wait=0.
- disp_alc rd=5, then jalr rs1=x5: bpu_wait held until wb_ret. Read occurs the cycle after retire; total stall = retire latency + 1.
- jalr rs1=x7 with exu_rf_rd_req=1 for 3 cycles: exu_rf_rd_gnt=1 and bpu_rf_rd_sel=0 for those 3 cycles. BPU is granted on cycle 4.
- OITF_DEPTH=2: 2 allocs give oitf_full=1. A third alloc with wb_ret=1 is rejected. Alloc+ret from count 1 keeps count 1 across pointer wrap.
- jalr rs1=x1 with ir_valid, ir_rd_wen=1, ir_rdidx=1:
  - With IFU_BPU_X1_DEP_EN: bpu_wait=1 until ir_valid=0.
  - Without it: bpu_wait=0.
- In WAIT, dec_flush=1: next cycle IDLE, bpu_wait=0, bpu_rs1_vld never asserted. Asserting rst low mid-WAIT returns all outputs to reset values immediately.
